// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF evaluation controller.
package puf_ctrl_pkg;

    localparam int DEF_N_BITS        = 8;
    localparam int DEF_N_EVALS       = 7;
    localparam int DEF_RESET_CYCLES  = 4;
    localparam int DEF_SETTLE_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/puf_eval_controller_if.sv
// Consumer-side request/response handshake of the PUF evaluation controller.
interface puf_eval_controller_if #(
    parameter int N_BITS = puf_ctrl_pkg::DEF_N_BITS
);
    logic              req;
    logic              busy;
    logic [N_BITS-1:0] resp;
    logic [N_BITS-1:0] unstable;
    logic              resp_valid;
    logic              resp_ready;

    modport master (
        output req, resp_ready,
        input  busy, resp, unstable, resp_valid
    );

    modport slave (
        input  req, resp_ready,
        output busy, resp, unstable, resp_valid
    );
endinterface

// File: rtl/puf_vote_accum.sv
// Per-bit ones-counters with majority and disagreement outputs.
module puf_vote_accum
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS  = DEF_N_BITS,
    parameter int N_EVALS = DEF_N_EVALS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              sample_en,
    input  logic [N_BITS-1:0] bits_in,
    output logic [N_BITS-1:0] maj,
    output logic [N_BITS-1:0] unstable
);
    localparam int ONES_W = cnt_w(N_EVALS + 1);

    logic [N_BITS-1:0][ONES_W-1:0] ones_q, ones_d;

    // maj/unstable look at the next count so the final sample is included
    // in the same cycle it is taken.
    always_comb begin
        ones_d   = ones_q;
        maj      = '0;
        unstable = '0;
        for (int i = 0; i < N_BITS; i++) begin
            if (clr)
                ones_d[i] = '0;
            else if (sample_en && bits_in[i])
                ones_d[i] = ones_q[i] + ONES_W'(1);
            maj[i]      = ones_d[i] > ONES_W'(N_EVALS / 2);
            unstable[i] = (ones_d[i] != '0) && (ones_d[i] != ONES_W'(N_EVALS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ones_q <= '0;
        else       ones_q <= ones_d;
    end

endmodule

// File: rtl/puf_eval_controller.sv
// Runs repeated clear/race/sample evaluations on a PUF bank and returns a
// majority-voted response plus an instability mask.
module puf_eval_controller
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS        = DEF_N_BITS,
    parameter int N_EVALS       = DEF_N_EVALS,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    puf_eval_controller_if.slave  host,
    output logic                  puf_start,
    output logic                  puf_reset,
    input  logic [N_BITS-1:0]     puf_out
);
    localparam int PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W     = cnt_w(PHASE_MAX + 1);
    localparam int EVAL_W    = cnt_w(N_EVALS);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [EVAL_W-1:0]  eval_q, eval_d;
    logic [N_BITS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_BITS-1:0]  resp_q, resp_d, unst_q, unst_d;
    logic               rv_q, rv_d, busy_q, busy_d;
    logic               start_q, start_d, prst_q, prst_d;
    logic               votes_clr, votes_sample;
    logic [N_BITS-1:0]  vote_maj, vote_unst;

    puf_vote_accum #(
        .N_BITS  (N_BITS),
        .N_EVALS (N_EVALS)
    ) u_votes (
        .clk       (clk),
        .reset     (reset),
        .clr       (votes_clr),
        .sample_en (votes_sample),
        .bits_in   (sync2_q),
        .maj       (vote_maj),
        .unstable  (vote_unst)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        eval_d       = eval_q;
        resp_d       = resp_q;
        unst_d       = unst_q;
        sync1_d      = puf_out;
        sync2_d      = sync1_q;
        votes_clr    = 1'b0;
        votes_sample = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host.req) begin
                    votes_clr = 1'b1;
                    tmr_d     = '0;
                    eval_d    = '0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (tmr_q == TMR_W'(RESET_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SAMPLE: begin
                votes_sample = 1'b1;
                if (eval_q < EVAL_W'(N_EVALS - 1)) begin
                    eval_d  = eval_q + EVAL_W'(1);
                    state_d = ST_CLEAR;
                end else begin
                    resp_d  = vote_maj;
                    unst_d  = vote_unst;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (host.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered so the
        // shared bank lines never glitch between START and reset.
        busy_d  = (state_d != ST_IDLE);
        rv_d    = (state_d == ST_DONE);
        start_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        prst_d  = !start_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            eval_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            prst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            eval_q  <= eval_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            prst_q  <= prst_d;
        end
    end

    assign host.busy       = busy_q;
    assign host.resp       = resp_q;
    assign host.unstable   = unst_q;
    assign host.resp_valid = rv_q;
    assign puf_start       = start_q;
    assign puf_reset       = prst_q;

endmodule

// File: tb/tb_puf_eval_controller.sv
// Self-checking bench for puf_eval_controller: table vectors, random runs
// against a vote-count model, and hand-written corner sequences.
module tb_puf_eval_controller;
    localparam int NB   = 8;
    localparam int NE   = 7;
    localparam int RC   = 4;
    localparam int SC   = 16;
    localparam int EVAL = RC + SC + 1;
    localparam int LAT  = 1 + NE * EVAL;

    logic          clk = 1'b0;
    logic          reset;
    logic          puf_start, puf_reset;
    logic [NB-1:0] puf_out;

    int errors = 0;
    int checks = 0;

    puf_eval_controller_if #(.N_BITS(NB)) bus ();

    puf_eval_controller #(
        .N_BITS(NB), .N_EVALS(NE), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (bus),
        .puf_start (puf_start),
        .puf_reset (puf_reset),
        .puf_out   (puf_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: count ones per bit across evaluations and vote.
    function automatic void model(input logic [NE-1:0][NB-1:0] p,
                                  output logic [NB-1:0] r, output logic [NB-1:0] u);
        for (int i = 0; i < NB; i++) begin
            int n = 0;
            for (int e = 0; e < NE; e++) n += int'(p[e][i]);
            r[i] = (n > NE / 2);
            u[i] = (n != 0) && (n != NE);
        end
    endfunction

    // Waveform monitor on the shared bank lines.
    int st_len = 0, rs_len = 0, st_runs = 0;
    int overlap = 0, wave_bad = 0, idle_bad = 0;
    bit after_start = 0;
    always @(negedge clk) begin
        if (reset) begin
            st_len = 0; rs_len = 0; after_start = 0;
        end else begin
            if (puf_start && puf_reset) overlap++;
            if (!bus.busy) begin
                after_start = 0;
                if (puf_reset !== 1'b1 || puf_start !== 1'b0) idle_bad++;
            end
            if (puf_start) st_len++;
            else if (st_len != 0) begin
                if (st_len != SC + 1) wave_bad++;
                st_runs++; st_len = 0; after_start = 1;
            end
            if (puf_reset) rs_len++;
            else if (rs_len != 0) begin
                if (after_start && rs_len != RC) wave_bad++;
                rs_len = 0;
            end
        end
    end

    // One full request/response. Each evaluation sees ~p[e] early and p[e]
    // only in its last five cycles, so only the sampling window counts.
    task automatic run(input string nm, input logic [NE-1:0][NB-1:0] p, input int hold,
                       input logic [NB-1:0] er, input logic [NB-1:0] eu);
        int early = 0, nobusy = 0, drift = 0;
        logic [NB-1:0] r0;
        bus.resp_ready = (hold == 0);
        puf_out = ~p[0];
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            int e, o;
            e = (c - 1) / EVAL;
            o = (c - 1) % EVAL;
            puf_out = (o >= EVAL - 5) ? p[e] : ~p[e];
            if (bus.busy !== 1'b1) nobusy++;
            if (bus.resp_valid !== 1'b0) early++;
            step();
        end
        chk({nm, " early_valid"}, 32'(early), 0);
        chk({nm, " busy_during_run"}, 32'(nobusy), 0);
        chk({nm, " resp_valid_at_lat"}, 32'(bus.resp_valid), 1);
        chk({nm, " resp"}, 32'(bus.resp), 32'(er));
        chk({nm, " unstable"}, 32'(bus.unstable), 32'(eu));
        if (hold > 0) begin
            r0 = bus.resp;
            for (int h = 0; h < hold; h++) begin
                bus.req = 1'($urandom_range(0, 1));
                if (bus.resp_valid !== 1'b1 || bus.resp !== r0 || bus.busy !== 1'b1) drift++;
                step();
            end
            bus.req = 1'b0;
            chk({nm, " hold_stable"}, 32'(drift), 0);
            bus.resp_ready = 1'b1;
        end
        step();
        chk({nm, " idle_after_hs"}, {30'd0, bus.busy, bus.resp_valid}, 0);
        chk({nm, " resp_kept"}, 32'(bus.resp), 32'(er));
        step();
        chk({nm, " stays_idle"}, 32'(bus.busy), 0);
        bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        string                 nm;
        logic [NE-1:0][NB-1:0] p;
        int                    hold;
        logic [NB-1:0]         er;
        logic [NB-1:0]         eu;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic [NE-1:0][NB-1:0] rp;
        logic [NB-1:0] mr, mu;
        int first, second, pulses, wbad;
        bit prev;

        tv[0] = '{"const_a5", {7{8'hA5}}, 0, 8'hA5, 8'h00};
        tv[1] = '{"bit0_4ones", {8'hA5, 8'hA4, 8'hA4, 8'hA4, 8'hA5, 8'hA5, 8'hA5}, 10, 8'hA5, 8'h01};
        tv[2] = '{"bit0_3ones", {8'h3D, 8'h3C, 8'h3C, 8'h3D, 8'h3C, 8'h3D, 8'h3C}, 0, 8'h3C, 8'h01};
        tv[3] = '{"all_zero", {7{8'h00}}, 2, 8'h00, 8'h00};
        tv[4] = '{"all_one", {7{8'hFF}}, 0, 8'hFF, 8'h00};
        tv[5] = '{"split_76", {8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80}, 3, 8'h80, 8'hC0};

        reset = 1'b1; bus.req = 1'b0; bus.resp_ready = 1'b0; puf_out = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst puf_reset", 32'(puf_reset), 1);
        chk("rst puf_start", 32'(puf_start), 0);
        chk("rst resp_valid", 32'(bus.resp_valid), 0);
        chk("rst resp_unstable", {16'd0, bus.resp, bus.unstable}, 0);
        step();

        foreach (tv[k]) run(tv[k].nm, tv[k].p, tv[k].hold, tv[k].er, tv[k].eu);

        for (int k = 0; k < 6; k++) begin
            for (int e = 0; e < NE; e++) rp[e] = 8'($urandom);
            model(rp, mr, mu);
            run($sformatf("rand%0d", k), rp, int'($urandom_range(0, 4)), mr, mu);
        end

        // Reset in the middle of the third evaluation's settle phase.
        bus.resp_ready = 1'b1;
        puf_out = 8'hFF;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        repeat (2 * EVAL + RC + 8) step();
        chk("mid_settle start", 32'(puf_start), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort puf_reset", 32'(puf_reset), 1);
        chk("abort resp_valid", 32'(bus.resp_valid), 0);
        chk("abort resp", 32'(bus.resp), 0);
        step();
        run("post_reset", {7{8'h0F}}, 0, 8'h0F, 8'h00);

        // req held high with ready high: back-to-back single-cycle pulses.
        bus.resp_ready = 1'b1;
        puf_out = 8'h5A;
        bus.req = 1'b1;
        first = -1; second = -1; pulses = 0; wbad = 0; prev = 0;
        for (int c = 1; c <= 400 && pulses < 2; c++) begin
            step();
            if (bus.resp_valid) begin
                if (prev) wbad++;
                else begin
                    pulses++;
                    if (pulses == 1) first = c; else second = c;
                end
            end
            prev = bus.resp_valid;
        end
        chk("b2b first_latency", 32'(first), LAT);
        chk("b2b resp", 32'(bus.resp), 32'h5A);
        chk("b2b interval", 32'(second - first), LAT + 1);
        step();
        chk("b2b pulse_width", 32'(wbad + int'(bus.resp_valid)), 0);
        bus.req = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (LAT + 3) step();
        chk("b2b drained", 32'(bus.busy), 0);

        chk("wave overlap", 32'(overlap), 0);
        chk("wave pulse_len", 32'(wave_bad), 0);
        chk("wave idle_levels", 32'(idle_bad), 0);
        chk("wave start_runs_seen", 32'(st_runs >= 10 * NE), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_eval_controller.md
# puf_eval_controller

Sequencing controller for a bank of latch-based one-bit PUF cells. On request, it runs repeated clear/race/sample evaluations on all cells in parallel, majority-votes each bit over an odd number of evaluations, and returns an N-bit response with a per-bit instability mask over a valid/ready handshake. It sits between the PUF bank and the consumer (key derivation or test readout). It is the only driver of the bank's shared START and reset lines.

## Interface
- N_BITS, 8, number of PUF cells and response width
- N_EVALS, 7, evaluations per response; odd, ≥1
- RESET_CYCLES, 4, cycles puf_reset is held per evaluation; ≥1
- SETTLE_CYCLES, 16, cycles puf_start is held before sampling; ≥4
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  start a response generation; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- puf_start  out  1  shared START to all PUF cells
- puf_reset  out  1  shared reset to all PUF cells
- puf_out  in  N_BITS  raw cell outputs; asynchronous
- resp  out  N_BITS  majority-voted response
- unstable  out  N_BITS  bit i set if evaluations of cell i disagreed
- resp_valid  out  1  resp/unstable valid
- resp_ready  in  1  consumer accepts response

## Operation
- puf_out passes through a 2-flop synchronizer per bit. Only synchronized values are sampled.
- FSM states: IDLE, CLEAR, SETTLE, SAMPLE, DONE.
- IDLE: puf_reset=1, puf_start=0.
  - If req=1: clear vote counters and eval counter, then go to CLEAR.
- CLEAR: puf_reset=1, puf_start=0 for RESET_CYCLES cycles, then go to SETTLE.
- SETTLE: puf_reset=0, puf_start=1 for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle): puf_reset=0, puf_start=1.
  - For every bit with synchronized puf_out=1, increment that bit's ones-count.
  - If eval count < N_EVALS-1: increment it and go to CLEAR. Otherwise go to DONE.
- DONE: puf_reset=1, puf_start=0, resp_valid=1.
  - resp[i] = ones[i] > N_EVALS/2.
  - unstable[i] = ones[i]≠0 and ones[i]≠N_EVALS.
  - Both are registered on entry to DONE and held constant while resp_valid=1.
- puf_start and puf_reset are never high in the same cycle.
- Counter widths:
  - ones-count: clog2(N_EVALS+1)
  - eval count: clog2(N_EVALS)
  - phase timer: clog2(max(RESET_CYCLES,SETTLE_CYCLES)+1)
  - No counter wraps within a legal run.
- req is ignored in every state except IDLE, including DONE.
- resp and unstable keep their last values after handshake and are cleared only by reset.

## Timing
- Reset values: puf_reset=1, puf_start=0, busy=0, resp=0, unstable=0, resp_valid=0, FSM in IDLE, all counters 0.
- req=1 in IDLE at cycle t: CLEAR begins at t+1.
- Each evaluation lasts RESET_CYCLES+SETTLE_CYCLES+1 cycles. Default: 21.
- resp_valid first rises at t+1+N_EVALS·(RESET_CYCLES+SETTLE_CYCLES+1). Default: t+148.
- Handshake completes on resp_valid & resp_ready in DONE. Next cycle: IDLE, resp_valid=0, busy=0.
  - If resp_ready is already high on DONE entry, resp_valid is high for exactly one cycle.
- Earliest new request: req sampled in the first IDLE cycle after the handshake.
- Reset asserted in any state: next cycle holds the reset values. No partial response and no resp_valid. A later req starts a full run.
- Sampling happens SETTLE_CYCLES cycles after puf_start rises, which leaves ≥2 cycles of synchronizer margin.

## Structure
- Shared package puf_ctrl_pkg contains:
  - the FSM state enum
  - a clog2-based width helper function
  - default parameter constants
- Sub-module puf_vote_accum, parameterized by N_BITS and N_EVALS, contains:
  - the per-bit ones-counters with clear and sample-enable inputs
  - combinational majority and unstable outputs
- The FSM, timers, synchronizer and output registers stay in puf_eval_controller.

## Test plan
- Constant puf_out=8'hA5, req pulse at t:
  - resp_valid rises at t+148 with resp=8'hA5, unstable=8'h00.
  - busy is high t+1..t+148.
- Per-evaluation drive of bit 0:
  - Pattern 1,1,1,0,0,0,1 (4 ones): resp[0]=1, unstable[0]=1.
  - Pattern 0,1,0,1,0,0,1 (3 ones): resp[0]=0, unstable[0]=1.
  - Other bits constant: unstable=0 for those bits.
- Waveform check:
  - Each evaluation shows puf_reset high exactly 4 cycles, then puf_start high exactly 17 cycles.
  - The two are never high together.
  - In IDLE, puf_reset=1 and puf_start=0.
- Backpressure:
  - resp_ready held low 10 cycles after resp_valid: resp_valid and resp remain stable, and req pulses are ignored.
  - resp_ready raised: IDLE the following cycle.
- Reset asserted mid-SETTLE of evaluation 3:
  - Next cycle: busy=0, puf_reset=1, resp_valid=0.
  - A fresh req yields resp_valid exactly 148 cycles later, with votes from the new run only.
- req held high continuously with resp_ready=1:
  - Back-to-back runs, each 148 cycles plus one IDLE cycle.
  - resp_valid is a single-cycle pulse per run.
